// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle CPU control unit: opcodes, state
// encodings, select codes and the control word driven by the decoder.
package mc_pkg;

    localparam int OP_W = 6;
    localparam int ST_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b010011;
    localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b100110;
    localparam logic [OP_W-1:0] OP_SLT   = 6'b100111;
    localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OP_W-1:0] OP_J     = 6'b111000;
    localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [ST_W-1:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b111;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       reg_wre;
        logic       mem_rd;
        logic       mem_wr;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_sel;
        logic       db_data_src;
        logic       wr_reg_d_src;
        logic [1:0] reg_dst;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic is_rtype(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SLT: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic is_itype_alu(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    function automatic logic is_ls(input logic [OP_W-1:0] op);
        return (op == OP_SW) || (op == OP_LW);
    endfunction

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode from the current state, the latched
// opcode and the ALU flags.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] opcode_i,
    input  logic            zero_i,
    input  logic            sign_i,
    output ctrl_t           ctrl_o
);

    logic alu_r;
    logic alu_i;
    logic br_taken;

    assign alu_r = is_rtype(opcode_i);
    assign alu_i = is_itype_alu(opcode_i);

    always_comb begin
        br_taken = 1'b0;
        case (opcode_i)
            OP_BEQ:  br_taken = zero_i;
            OP_BNE:  br_taken = ~zero_i;
            OP_BLTZ: br_taken = sign_i;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_IF: ctrl_o.ir_wre = 1'b1;

            S_ID: begin
                if (opcode_i == OP_J) begin
                    ctrl_o.pc_wre = 1'b1;
                    ctrl_o.pc_src = PC_JUMP;
                end else if (opcode_i == OP_JR) begin
                    ctrl_o.pc_wre = 1'b1;
                    ctrl_o.pc_src = PC_RS;
                end else if (opcode_i == OP_JAL) begin
                    ctrl_o.pc_wre       = 1'b1;
                    ctrl_o.pc_src       = PC_JUMP;
                    ctrl_o.reg_wre      = 1'b1;
                    ctrl_o.reg_dst      = RD_RA;
                    ctrl_o.wr_reg_d_src = 1'b0;
                end else if (!(alu_r || alu_i || is_ls(opcode_i) ||
                               is_branch(opcode_i) || opcode_i == OP_HALT)) begin
                    // Undefined opcodes retire as a NOP.
                    ctrl_o.pc_wre = 1'b1;
                    ctrl_o.pc_src = PC_NEXT;
                end
            end

            // ALU controls stay valid through write-back so the result bus holds.
            S_EXE_AL, S_WB_AL: begin
                ctrl_o.alu_src_b = alu_i;
                ctrl_o.ext_sel   = (opcode_i == OP_ADDIU) || (opcode_i == OP_SLTI);
                ctrl_o.alu_src_a = (opcode_i == OP_SLL);
                case (opcode_i)
                    OP_SUB:          ctrl_o.alu_op = ALU_SUB;
                    OP_SLL:          ctrl_o.alu_op = ALU_SLL;
                    OP_ORI:          ctrl_o.alu_op = ALU_OR;
                    OP_AND, OP_ANDI: ctrl_o.alu_op = ALU_AND;
                    OP_SLT, OP_SLTI: ctrl_o.alu_op = ALU_SLT;
                    OP_XORI:         ctrl_o.alu_op = ALU_XOR;
                    default:         ctrl_o.alu_op = ALU_ADD;
                endcase
                if (state_i == S_WB_AL) begin
                    ctrl_o.reg_wre      = 1'b1;
                    ctrl_o.db_data_src  = 1'b0;
                    ctrl_o.wr_reg_d_src = 1'b1;
                    ctrl_o.reg_dst      = alu_r ? RD_RD : RD_RT;
                    ctrl_o.pc_wre       = 1'b1;
                    ctrl_o.pc_src       = PC_NEXT;
                end
            end

            S_EXE_LS, S_MEM, S_WB_LD: begin
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.ext_sel   = 1'b1;
                if (state_i == S_MEM) begin
                    if (opcode_i == OP_LW) begin
                        ctrl_o.mem_rd = 1'b1;
                    end else begin
                        ctrl_o.mem_wr = (opcode_i == OP_SW);
                        ctrl_o.pc_wre = 1'b1;
                    end
                end else if (state_i == S_WB_LD) begin
                    ctrl_o.mem_rd       = 1'b1;
                    ctrl_o.reg_wre      = 1'b1;
                    ctrl_o.db_data_src  = 1'b1;
                    ctrl_o.wr_reg_d_src = 1'b1;
                    ctrl_o.reg_dst      = RD_RT;
                    ctrl_o.pc_wre       = 1'b1;
                end
            end

            S_EXE_BR: begin
                ctrl_o.alu_op  = ALU_SUB;
                ctrl_o.ext_sel = 1'b1;
                ctrl_o.pc_wre  = 1'b1;
                ctrl_o.pc_src  = br_taken ? PC_BRANCH : PC_NEXT;
            end

            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: state register and next-state logic; all
// outputs are decoded combinationally by mc_ctrl_decode.
//
// state  | meaning
// IF     | fetch, latch IR
// ID     | decode; jumps, jal and NOP retire here
// EXE_AL | ALU operation
// WB_AL  | ALU result write-back
// EXE_LS | load/store address calculation
// MEM    | data memory access; sw retires here
// WB_LD  | load write-back
// EXE_BR | branch compare and PC update
// HALT   | stopped until reset
module multi_cycle_ctrl
    import mc_pkg::*;
#(
    parameter int OP_W = mc_pkg::OP_W,
    parameter int ST_W = mc_pkg::ST_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            sign,
    output logic            pc_wre,
    output logic            ir_wre,
    output logic            reg_wre,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            alu_src_a,
    output logic            alu_src_b,
    output logic            ext_sel,
    output logic            db_data_src,
    output logic            wr_reg_d_src,
    output logic [1:0]      reg_dst,
    output logic [1:0]      pc_src,
    output logic [2:0]      alu_op,
    output logic [ST_W-1:0] state
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (is_rtype(opcode) || is_itype_alu(opcode)) state_d = S_EXE_AL;
                else if (is_ls(opcode))                      state_d = S_EXE_LS;
                else if (is_branch(opcode))                  state_d = S_EXE_BR;
                else if (opcode == OP_HALT)                  state_d = S_HALT;
                else                                         state_d = S_IF;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IF;
        else      state_q <= state_d;
    end

    mc_ctrl_decode u_decode (
        .state_i  (state_q),
        .opcode_i (opcode),
        .zero_i   (zero),
        .sign_i   (sign),
        .ctrl_o   (ctrl)
    );

    assign pc_wre       = ctrl.pc_wre;
    assign ir_wre       = ctrl.ir_wre;
    assign reg_wre      = ctrl.reg_wre;
    assign mem_rd       = ctrl.mem_rd;
    assign mem_wr       = ctrl.mem_wr;
    assign alu_src_a    = ctrl.alu_src_a;
    assign alu_src_b    = ctrl.alu_src_b;
    assign ext_sel      = ctrl.ext_sel;
    assign db_data_src  = ctrl.db_data_src;
    assign wr_reg_d_src = ctrl.wr_reg_d_src;
    assign reg_dst      = ctrl.reg_dst;
    assign pc_src       = ctrl.pc_src;
    assign alu_op       = ctrl.alu_op;
    assign state        = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: table of per-instruction vectors with
// hand-computed control values, plus reset/halt corner sequences.
module tb_multi_cycle_ctrl;

    logic       clk, rst, zero, sign;
    logic [5:0] opcode;
    logic       pc_wre, ir_wre, reg_wre, mem_rd, mem_wr;
    logic       alu_src_a, alu_src_b, ext_sel, db_data_src, wr_reg_d_src;
    logic [1:0] reg_dst, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;

    int ntests = 0;
    int nfail  = 0;

    multi_cycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .sign(sign),
        .pc_wre(pc_wre), .ir_wre(ir_wre), .reg_wre(reg_wre),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_sel(ext_sel), .db_data_src(db_data_src),
        .wr_reg_d_src(wr_reg_d_src), .reg_dst(reg_dst), .pc_src(pc_src),
        .alu_op(alu_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       s;
        int         cpi;
        logic [3:0] fin_state;
        logic [1:0] fin_pc_src;
        logic       fin_reg_wre;
        logic [1:0] fin_reg_dst;
        logic       fin_mem_wr;
        logic       fin_db;
        logic       fin_wrsrc;
        int         mem_rd_cyc;
        logic [3:0] exe_state;  // 4'hF: no EXE state for this instruction
        logic [2:0] exe_alu;
        logic       exe_a;
        logic       exe_b;
        int         exe_ext;    // -1: not checked
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0, pcw = 0, rw = 0, mw = 0, mr = 0, irw = 0, exe_seen = 0;
        logic [3:0] f_state = 4'hE;
        logic [1:0] f_pc_src = 2'bxx, f_reg_dst = 2'bxx;
        logic f_reg_wre = 1'bx, f_mem_wr = 1'bx, f_mem_rd = 1'bx, f_db = 1'bx, f_wrsrc = 1'bx;
        string tag = $sformatf("v%0d_op%06b", idx, v.op);
        opcode = v.op; zero = v.z; sign = v.s;
        do begin
            if (pc_wre) begin
                pcw++;
                f_state = state; f_pc_src = pc_src; f_reg_wre = reg_wre;
                f_reg_dst = reg_dst; f_mem_wr = mem_wr; f_mem_rd = mem_rd;
                f_db = db_data_src; f_wrsrc = wr_reg_d_src;
            end
            if (reg_wre) rw++;
            if (mem_wr)  mw++;
            if (mem_rd)  mr++;
            if (ir_wre)  irw++;
            if (state == v.exe_state) begin
                exe_seen++;
                check({tag, "_exe_alu_op"}, 32'(alu_op), 32'(v.exe_alu));
                check({tag, "_exe_src_a"}, 32'(alu_src_a), 32'(v.exe_a));
                check({tag, "_exe_src_b"}, 32'(alu_src_b), 32'(v.exe_b));
                if (v.exe_ext >= 0) check({tag, "_exe_ext_sel"}, 32'(ext_sel), 32'(v.exe_ext));
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end while (state != 4'b0000 && cyc < 12);
        check({tag, "_cpi"}, cyc, v.cpi);
        check({tag, "_pc_wre_cycles"}, pcw, 1);
        check({tag, "_ir_wre_cycles"}, irw, 1);
        check({tag, "_exe_seen"}, exe_seen, (v.exe_state == 4'hF) ? 0 : 1);
        check({tag, "_final_state"}, 32'(f_state), 32'(v.fin_state));
        check({tag, "_pc_src"}, 32'(f_pc_src), 32'(v.fin_pc_src));
        check({tag, "_reg_wre_final"}, 32'(f_reg_wre), 32'(v.fin_reg_wre));
        check({tag, "_reg_wre_cycles"}, rw, v.fin_reg_wre ? 1 : 0);
        check({tag, "_mem_wr_final"}, 32'(f_mem_wr), 32'(v.fin_mem_wr));
        check({tag, "_mem_wr_cycles"}, mw, v.fin_mem_wr ? 1 : 0);
        check({tag, "_mem_rd_cycles"}, mr, v.mem_rd_cyc);
        check({tag, "_mem_rd_final"}, 32'(f_mem_rd), (v.mem_rd_cyc != 0) ? 1 : 0);
        if (v.fin_reg_wre) begin
            check({tag, "_reg_dst"}, 32'(f_reg_dst), 32'(v.fin_reg_dst));
            check({tag, "_wr_reg_d_src"}, 32'(f_wrsrc), 32'(v.fin_wrsrc));
            if (v.fin_wrsrc) check({tag, "_db_data_src"}, 32'(f_db), 32'(v.fin_db));
        end
    endtask

    initial begin
        //           op        z  s  cpi fin    pcs    rw  rdst   mw db ws mrd exe    alu     a  b  ext
        vecs[0]  = '{6'b000000, 0, 0, 4, 4'h7, 2'b00, 1, 2'b10, 0, 0, 1, 0, 4'h6, 3'b000, 0, 0, -1};
        vecs[1]  = '{6'b000001, 1, 1, 4, 4'h7, 2'b00, 1, 2'b10, 0, 0, 1, 0, 4'h6, 3'b001, 0, 0, -1};
        vecs[2]  = '{6'b000010, 0, 0, 4, 4'h7, 2'b00, 1, 2'b01, 0, 0, 1, 0, 4'h6, 3'b000, 0, 1,  1};
        vecs[3]  = '{6'b010000, 0, 0, 4, 4'h7, 2'b00, 1, 2'b10, 0, 0, 1, 0, 4'h6, 3'b100, 0, 0, -1};
        vecs[4]  = '{6'b010001, 0, 0, 4, 4'h7, 2'b00, 1, 2'b01, 0, 0, 1, 0, 4'h6, 3'b100, 0, 1,  0};
        vecs[5]  = '{6'b010010, 0, 0, 4, 4'h7, 2'b00, 1, 2'b01, 0, 0, 1, 0, 4'h6, 3'b011, 0, 1,  0};
        vecs[6]  = '{6'b010011, 0, 0, 4, 4'h7, 2'b00, 1, 2'b01, 0, 0, 1, 0, 4'h6, 3'b111, 0, 1,  0};
        vecs[7]  = '{6'b011000, 0, 0, 4, 4'h7, 2'b00, 1, 2'b10, 0, 0, 1, 0, 4'h6, 3'b010, 1, 0, -1};
        vecs[8]  = '{6'b100110, 0, 1, 4, 4'h7, 2'b00, 1, 2'b01, 0, 0, 1, 0, 4'h6, 3'b101, 0, 1,  1};
        vecs[9]  = '{6'b100111, 0, 0, 4, 4'h7, 2'b00, 1, 2'b10, 0, 0, 1, 0, 4'h6, 3'b101, 0, 0, -1};
        vecs[10] = '{6'b110001, 0, 0, 5, 4'h4, 2'b00, 1, 2'b01, 0, 1, 1, 2, 4'h2, 3'b000, 0, 1,  1};
        vecs[11] = '{6'b110000, 0, 0, 4, 4'h3, 2'b00, 0, 2'b00, 1, 0, 0, 0, 4'h2, 3'b000, 0, 1,  1};
        vecs[12] = '{6'b110100, 1, 0, 3, 4'h5, 2'b01, 0, 2'b00, 0, 0, 0, 0, 4'h5, 3'b001, 0, 0,  1};
        vecs[13] = '{6'b110100, 0, 1, 3, 4'h5, 2'b00, 0, 2'b00, 0, 0, 0, 0, 4'h5, 3'b001, 0, 0,  1};
        vecs[14] = '{6'b110101, 0, 0, 3, 4'h5, 2'b01, 0, 2'b00, 0, 0, 0, 0, 4'h5, 3'b001, 0, 0,  1};
        vecs[15] = '{6'b110101, 1, 0, 3, 4'h5, 2'b00, 0, 2'b00, 0, 0, 0, 0, 4'h5, 3'b001, 0, 0,  1};
        vecs[16] = '{6'b110110, 0, 1, 3, 4'h5, 2'b01, 0, 2'b00, 0, 0, 0, 0, 4'h5, 3'b001, 0, 0,  1};
        vecs[17] = '{6'b110110, 1, 0, 3, 4'h5, 2'b00, 0, 2'b00, 0, 0, 0, 0, 4'h5, 3'b001, 0, 0,  1};
        vecs[18] = '{6'b111010, 0, 0, 2, 4'h1, 2'b11, 1, 2'b00, 0, 0, 0, 0, 4'hF, 3'b000, 0, 0, -1};
        vecs[19] = '{6'b111001, 0, 0, 2, 4'h1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 4'hF, 3'b000, 0, 0, -1};
        vecs[20] = '{6'b101010, 1, 1, 2, 4'h1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 4'hF, 3'b000, 0, 0, -1};

        rst = 1'b0; opcode = 6'b000000; zero = 1'b0; sign = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'h0);
        check("rst_ir_wre", 32'(ir_wre), 32'h1);
        check("rst_wr_enables", {pc_wre, reg_wre, mem_rd, mem_wr}, 4'b0000);
        check("rst_pc_src_alu_op", {pc_src, alu_op}, 5'b00000);
        rst = 1'b1;

        // Table: each entry runs one complete instruction from IF back to IF.
        for (int i = 0; i < 21; i++) run_vec(i, vecs[i]);

        run_vec(100, '{6'b111000, 0, 0, 2, 4'h1, 2'b11, 0, 2'b00, 0, 0, 0, 0, 4'hF, 3'b000, 0, 0, -1});

        // halt: parks in HALT regardless of flags, then async reset.
        opcode = 6'b111111;
        @(posedge clk); @(negedge clk);
        check("halt_id_pc_wre", 32'(pc_wre), 32'h0);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            zero = i[0]; sign = i[1];
            #1;
            check($sformatf("halt_c%0d", i), {state, pc_wre, reg_wre, mem_wr, mem_rd}, {4'b1000, 4'b0000});
            @(posedge clk); @(negedge clk);
        end
        #1 rst = 1'b0;
        #1;
        check("halt_async_rst_state", 32'(state), 32'h0);
        check("halt_async_rst_ir_wre", 32'(ir_wre), 32'h1);
        @(negedge clk);
        rst = 1'b1;

        // lw interrupted by reset while in MEM: no register write may occur.
        begin
            int rw = 0;
            opcode = 6'b110001; zero = 1'b0; sign = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (reg_wre) rw++;
                @(posedge clk); @(negedge clk);
            end
            check("lw_abort_in_mem", 32'(state), 32'h3);
            check("lw_abort_mem_rd", 32'(mem_rd), 32'h1);
            if (reg_wre) rw++;
            #1 rst = 1'b0;
            #1;
            check("lw_abort_async_state", 32'(state), 32'h0);
            for (int i = 0; i < 2; i++) begin
                if (reg_wre || mem_wr || pc_wre) rw++;
                @(posedge clk); @(negedge clk);
            end
            check("lw_abort_state_held", 32'(state), 32'h0);
            check("lw_abort_no_writes", rw, 0);
            rst = 1'b1;
        end

        // Machine recovers normally after the aborted load.
        run_vec(101, vecs[10]);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
